// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter slice.
// The PARITY state is always present so the state encoding is identical in every build.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick is high on the last clock of each CLKS_PER_BIT-cycle bit period.
// clr holds the count at zero so the first period after clr drops is a full one.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("baud_tick_gen: CLKS_PER_BIT must be >= 1");
    end

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Start/stop-framed serial transmitter, LSB first, every output registered.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             newd,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_t        state, state_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             tx_n, ready_n, busy_n, done_n;
    logic             tick, tick_clr;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity, parity_n;
`endif

    // The bit timer idles at zero, so every state entered on tick starts a full bit period.
    assign tick_clr = (state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_n      = tx;
        ready_n   = ready;
        busy_n    = busy;
        done_n    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_n  = parity;
`endif
        case (state)
            IDLE: begin
                if (newd && ready) begin
                    state_n = START;
                    shreg_n = din;
                    tx_n    = 1'b0;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    parity_n = ^din;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        bit_cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_n   = PARITY;
                        tx_n      = parity;
`else
                        state_n   = STOP;
                        tx_n      = TX_IDLE_LEVEL;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = TX_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = TX_IDLE_LEVEL;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= TX_IDLE_LEVEL;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            ready   <= ready_n;
            busy    <= busy_n;
            done    <= done_n;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed and random frames compared against a bit-level frame model.
// Honours SERIAL_TX_PARITY_EN so the same bench covers both builds.
module tb_serial_tx;

    localparam int W = 8;
    localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (W + 2 + PB) * C;

    typedef logic lvl_q_t[$];

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         newd = 1'b0;
    logic [W-1:0] din  = '0;
    logic         ready, tx, busy, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t1, t2;

    serial_tx #(
        .WIDTH(W),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .newd (newd),
        .ready(ready),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line levels of one frame, one entry per serial bit: start, data LSB first, [parity], stop.
    function automatic lvl_q_t frame_levels(input logic [W-1:0] d);
        lvl_q_t q;
        q.push_back(1'b0);
        for (int b = 0; b < W; b++) q.push_back(d[b]);
        if (PB == 1) q.push_back(^d);
        q.push_back(1'b1);
        return q;
    endfunction

    task automatic accept(input logic [W-1:0] d);
        check("accept_ready", ready, 1'b1);
        din  = d;
        newd = 1'b1;
        step();
        newd = 1'b0;
    endtask

    // Checks the frame from its first start-bit cycle through the done cycle; din is scrambled
    // throughout, an optional newd poke lands mid-frame, and chain offers the next word in the done cycle.
    task automatic expect_frame(input logic [W-1:0] d, input int poke_at, input logic [W-1:0] poke_d,
                                input bit chain, input logic [W-1:0] chain_d, output int done_cyc);
        lvl_q_t q;
        q = frame_levels(d);
        for (int i = 0; i < q.size() * C; i++) begin
            check("tx_bit", tx, q[i/C]);
            check("busy_in_frame", busy, 1'b1);
            check("ready_in_frame", ready, 1'b0);
            check("done_in_frame", done, 1'b0);
            if (i == poke_at) begin
                din  = poke_d;
                newd = 1'b1;
            end else begin
                din  = W'($urandom);
                newd = 1'b0;
            end
            step();
        end
        newd = 1'b0;
        check("done_pulse", done, 1'b1);
        check("done_ready", ready, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_tx", tx, 1'b1);
        done_cyc = cyc;
        if (chain) begin
            din  = chain_d;
            newd = 1'b1;
        end
        step();
        newd = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("after_done_ready", ready, chain ? 1'b0 : 1'b1);
        check("after_done_tx", tx, chain ? 1'b0 : 1'b1);
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_tx", tx, 1'b1);
            check("idle_ready", ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            step();
        end
    endtask

    initial begin
        lvl_q_t       q;
        logic [W-1:0] r0, r1;

        // Reset held two cycles, then an idle line with no newd.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        expect_idle(20);

        // Single frame.
        accept(8'hA5);
        expect_frame(8'hA5, -1, '0, 1'b0, '0, t1);
        expect_idle(3);

        // Back-to-back: the done cycle doubles as the accept cycle of the next frame,
        // so done pulses are one frame plus that single accept cycle apart.
        accept(8'h3C);
        expect_frame(8'h3C, -1, '0, 1'b1, 8'hFF, t1);
        expect_frame(8'hFF, -1, '0, 1'b0, '0, t2);
        check("b2b_done_spacing", t2 - t1, FRAME + 1);
        expect_idle(3);

        // newd pulsed with 8'h80 at frame cycle 10 is ignored and not queued.
        accept(8'h01);
        expect_frame(8'h01, 9, 8'h80, 1'b0, '0, t1);
        expect_idle(2 * C * 12);

        // Reset during data bit 3 aborts the frame with no done pulse.
        accept(8'h55);
        q = frame_levels(8'h55);
        for (int i = 0; i < 18; i++) begin
            check("abort_tx_bit", tx, q[i/C]);
            if (i == 17) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        check("abort_tx", tx, 1'b1);
        check("abort_ready", ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        expect_idle(50);
        accept(8'hAA);
        expect_frame(8'hAA, -1, '0, 1'b0, '0, t1);

        // Word with odd parity.
        accept(8'h07);
        expect_frame(8'h07, -1, '0, 1'b0, '0, t1);

        // Random words, the last pair chained back-to-back.
        for (int n = 0; n < 4; n++) begin
            r0 = W'($urandom);
            accept(r0);
            expect_frame(r0, int'($urandom_range(0, FRAME - 2)), W'($urandom), 1'b0, '0, t1);
        end
        r0 = W'($urandom);
        r1 = W'($urandom);
        accept(r0);
        expect_frame(r0, -1, '0, 1'b1, r1, t1);
        expect_frame(r1, -1, '0, 1'b0, '0, t2);
        check("rand_b2b_spacing", t2 - t1, FRAME + 1);
        expect_idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
